led_seq_ctrl: RTL and testbench

//   Programmable sequencer that drives the 6-LED bank from an 8-entry pattern table.

---
 rtl/led_pkg.sv | 26 ++
 rtl/led_dwell_timer.sv | 33 +++
 rtl/led_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_led_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants, state encoding and a small legality helper for the LED sequencer.
package led_pkg;

  localparam int NUM_LEDS = 6;
  localparam int DEPTH    = 8;
  localparam int ADDR_W   = 3;
  localparam int DWELL_W  = 24;
  localparam int LEN_W    = 4;
  localparam int LOOP_W   = 8;

  localparam logic [NUM_LEDS-1:0] IDLE_PATTERN = 6'b111110;

  // Half-second dwell at a 27 MHz system clock (cycles minus one).
  localparam logic [DWELL_W-1:0] DWELL_500MS = 24'd13_499_999;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // A playback length is usable only if it names at least one and at most DEPTH entries.
  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(DEPTH));
  endfunction

endpackage

// File: rtl/led_dwell_timer.sv
// Per-step dwell timer: counts 0..dwell_l while running, flags the last cycle of each step.
module led_dwell_timer
  import led_pkg::*;
(
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               run,
  output logic               step_tick
);

  logic [DWELL_W-1:0] dwell_l;
  logic [DWELL_W-1:0] tick;

  // Latch the dwell on load; count while running, wrap at dwell_l; hold at zero when idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dwell_l <= '0;
      tick    <= '0;
    end else if (load) begin
      dwell_l <= dwell;
      tick    <= '0;
    end else if (run) begin
      tick <= (tick == dwell_l) ? '0 : tick + DWELL_W'(1);
    end else begin
      tick <= '0;
    end
  end

  assign step_tick = run && (tick == dwell_l);

endmodule

// File: rtl/led_seq_ctrl.sv
// Pattern-table LED sequencer: host loads up to DEPTH patterns, then plays them with a
// programmable dwell per step and a loop count (0 = forever).
module led_seq_ctrl
  import led_pkg::*;
(
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [NUM_LEDS-1:0] cfg_data,
  input  logic [LEN_W-1:0]    seq_len,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [LOOP_W-1:0]   loop_cnt,
  input  logic                start,
  input  logic                stop,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  seq_state_e                       state;
  logic [DEPTH-1:0][NUM_LEDS-1:0]   pat_tbl;
  logic [ADDR_W-1:0]                idx;
  logic [LOOP_W-1:0]                loops;
  logic [LOOP_W-1:0]                loop_cnt_l;
  logic [LEN_W-1:0]                 len_l;

  logic start_ok;
  logic step_tick;
  logic at_end;
  logic last_loop;
  logic [ADDR_W-1:0] idx_nxt;

  // Stop has priority over start, so a simultaneous start/stop in IDLE launches nothing.
  assign start_ok  = (state == ST_IDLE) && start && !stop && len_ok(seq_len);
  assign idx_nxt   = idx + ADDR_W'(1);
  assign at_end    = ({1'b0, idx} == (len_l - LEN_W'(1)));
  // Widened compare so loops+1 never wraps against a latched count of 255.
  assign last_loop = (({1'b0, loops} + 9'd1) == {1'b0, loop_cnt_l});

  led_dwell_timer u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (start_ok),
    .dwell     (dwell),
    .run       (state == ST_RUN),
    .step_tick (step_tick)
  );

  // Pattern table: writable only while idle so playback never sees a half-updated sequence.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pat_tbl <= '0;
    end else if (cfg_we && (state == ST_IDLE)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cfg_addr == ADDR_W'(i)) pat_tbl[i] <= cfg_data;
      end
    end
  end

  // Playback FSM with registered LED, busy and single-cycle done/cfg_err pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      led        <= IDLE_PATTERN;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      idx        <= '0;
      loops      <= '0;
      len_l      <= '0;
      loop_cnt_l <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            if (len_ok(seq_len)) begin
              len_l      <= seq_len;
              loop_cnt_l <= loop_cnt;
              led        <= pat_tbl[0];
              busy       <= 1'b1;
              idx        <= '0;
              loops      <= '0;
              state      <= ST_RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Table writes are dropped while playing; flag them to the host.
          if (cfg_we) cfg_err <= 1'b1;
          if (stop) begin
            led   <= IDLE_PATTERN;
            busy  <= 1'b0;
            idx   <= '0;
            state <= ST_IDLE;
          end else if (step_tick) begin
            if (!at_end) begin
              idx <= idx_nxt;
              led <= pat_tbl[idx_nxt];
            end else begin
              idx <= '0;
              if (loop_cnt_l == '0) begin
                led <= pat_tbl[0];
              end else if (last_loop) begin
                led   <= IDLE_PATTERN;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= ST_IDLE;
              end else begin
                loops <= loops + LOOP_W'(1);
                led   <= pat_tbl[0];
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scenario bench for led_seq_ctrl: a table mirror plus nested loops over loops/steps/dwell
// give the expected LED stream each cycle.
module tb_led_seq_ctrl;
  import led_pkg::*;

  logic                sys_clk = 1'b0;
  logic                sys_rst_n = 1'b1;
  logic                cfg_we = 1'b0;
  logic [ADDR_W-1:0]   cfg_addr = '0;
  logic [NUM_LEDS-1:0] cfg_data = '0;
  logic [LEN_W-1:0]    seq_len = '0;
  logic [DWELL_W-1:0]  dwell = '0;
  logic [LOOP_W-1:0]   loop_cnt = '0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic [NUM_LEDS-1:0] led;
  logic                busy, done, cfg_err;

  int npass = 0;
  int ntot  = 0;
  logic [NUM_LEDS-1:0] tbl [DEPTH];

  led_seq_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .seq_len(seq_len), .dwell(dwell), .loop_cnt(loop_cnt),
    .start(start), .stop(stop), .led(led), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time expired, want summary before timeout");
    $fatal(1, "watchdog");
  end

  task automatic wr(input int a, input logic [NUM_LEDS-1:0] d);
    cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_data = d;
    @(negedge sys_clk);
    cfg_we = 1'b0;
    tbl[a] = d;
  endtask

  task automatic fill_random();
    for (int a = 0; a < DEPTH; a++) wr(a, NUM_LEDS'($urandom));
  endtask

  // Finite playback; optional noise on the sampled inputs must not disturb the run.
  task automatic test_play(input int len, input int dw, input int lc, input bit noise, input string nm);
    seq_len = LEN_W'(len); dwell = DWELL_W'(dw); loop_cnt = LOOP_W'(lc); start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int l = 0; l < lc; l++)
      for (int s = 0; s < len; s++)
        for (int d = 0; d <= dw; d++) begin
          ntot++;
          if (led !== tbl[s] || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL %s loop%0d step%0d cyc%0d: led=%b busy=%b done=%b, want led=%b busy=1 done=0",
                     nm, l, s, d, led, busy, done, tbl[s]);
          else npass++;
          if (noise) begin
            start = 1'($urandom); seq_len = LEN_W'($urandom);
            dwell = DWELL_W'($urandom_range(0, 7)); loop_cnt = LOOP_W'($urandom);
          end
          @(negedge sys_clk);
        end
    ntot++;
    if (led !== IDLE_PATTERN || busy !== 1'b0 || done !== 1'b1)
      $display("FAIL %s end: led=%b busy=%b done=%b, want led=%b busy=0 done=1", nm, led, busy, done, IDLE_PATTERN);
    else npass++;
    start = 1'b0;
    @(negedge sys_clk);
    ntot++;
    if (done !== 1'b0 || busy !== 1'b0 || led !== IDLE_PATTERN)
      $display("FAIL %s post: led=%b busy=%b done=%b, want idle, done=0", nm, led, busy, done);
    else npass++;
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    ntot++;
    if (led !== IDLE_PATTERN || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0)
      $display("FAIL reset: led=%b busy=%b done=%b cfg_err=%b, want %b/0/0/0", led, busy, done, cfg_err, IDLE_PATTERN);
    else npass++;
    for (int a = 0; a < DEPTH; a++) tbl[a] = '0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_spec_vector();
    logic [NUM_LEDS-1:0] pats [6];
    pats = '{6'h01, 6'h04, 6'h02, 6'h08, 6'h00, 6'h02};
    for (int a = 0; a < 6; a++) wr(a, pats[a]);
    test_play(6, 3, 2, 1'b0, "spec_vec");
  endtask

  task automatic test_random_finite();
    for (int it = 0; it < 4; it++) begin
      fill_random();
      test_play($urandom_range(1, 8), $urandom_range(0, 3), $urandom_range(1, 3), 1'b1, "rand_finite");
    end
    test_play(8, 0, 1, 1'b0, "len8_dw0");
    test_play(1, 0, 1, 1'b0, "len1_dw0");
  endtask

  task automatic test_infinite();
    fill_random();
    seq_len = 4'd2; dwell = '0; loop_cnt = '0; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      ntot++;
      if (led !== tbl[k % 2] || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL infinite cyc%0d: led=%b busy=%b done=%b, want led=%b busy=1 done=0",
                 k, led, busy, done, tbl[k % 2]);
      else npass++;
      @(negedge sys_clk);
    end
    stop = 1'b1;
    @(negedge sys_clk);
    stop = 1'b0;
    ntot++;
    if (led !== IDLE_PATTERN || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL infinite_stop: led=%b busy=%b done=%b, want %b/0/0", led, busy, done, IDLE_PATTERN);
    else npass++;
  endtask

  task automatic test_bad_len();
    logic [LEN_W-1:0] bad [3];
    bad = '{4'd0, 4'd9, 4'd15};
    for (int i = 0; i < 3; i++) begin
      seq_len = bad[i]; start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      ntot++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || led !== IDLE_PATTERN)
        $display("FAIL bad_len%0d: cfg_err=%b busy=%b led=%b, want 1/0/%b", bad[i], cfg_err, busy, led, IDLE_PATTERN);
      else npass++;
      @(negedge sys_clk);
      ntot++;
      if (cfg_err !== 1'b0 || busy !== 1'b0)
        $display("FAIL bad_len_pulse%0d: cfg_err=%b busy=%b, want 0/0", bad[i], cfg_err, busy);
      else npass++;
    end
  endtask

  task automatic test_write_in_run();
    int a;
    fill_random();
    seq_len = 4'd3; dwell = 24'd1; loop_cnt = '0; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (3) @(negedge sys_clk);
    a = $urandom_range(0, DEPTH - 1);
    cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_data = ~tbl[a];
    @(negedge sys_clk);
    cfg_we = 1'b0;
    ntot++;
    if (cfg_err !== 1'b1 || busy !== 1'b1)
      $display("FAIL run_write: cfg_err=%b busy=%b, want 1/1", cfg_err, busy);
    else npass++;
    @(negedge sys_clk);
    ntot++;
    if (cfg_err !== 1'b0) $display("FAIL run_write_pulse: cfg_err=%b, want 0", cfg_err);
    else npass++;
    stop = 1'b1;
    @(negedge sys_clk);
    stop = 1'b0;
    test_play(8, 0, 1, 1'b0, "table_after_run_write");
  endtask

  task automatic test_start_stop_idle();
    seq_len = 4'd4; dwell = '0; loop_cnt = 8'd1; start = 1'b1; stop = 1'b1;
    @(negedge sys_clk);
    start = 1'b0; stop = 1'b0;
    ntot++;
    if (busy !== 1'b0 || led !== IDLE_PATTERN || cfg_err !== 1'b0)
      $display("FAIL start_stop_idle: busy=%b led=%b cfg_err=%b, want 0/%b/0", busy, led, cfg_err, IDLE_PATTERN);
    else npass++;
    @(negedge sys_clk);
    ntot++;
    if (busy !== 1'b0) $display("FAIL start_stop_idle2: busy=%b, want 0", busy);
    else npass++;
  endtask

  task automatic test_stop_on_final();
    fill_random();
    seq_len = 4'd2; dwell = 24'd1; loop_cnt = 8'd1; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (3) @(negedge sys_clk);
    ntot++;
    if (busy !== 1'b1 || led !== tbl[1])
      $display("FAIL final_pre: busy=%b led=%b, want 1/%b", busy, led, tbl[1]);
    else npass++;
    stop = 1'b1;
    @(negedge sys_clk);
    stop = 1'b0;
    ntot++;
    if (done !== 1'b0 || busy !== 1'b0 || led !== IDLE_PATTERN)
      $display("FAIL final_stop: done=%b busy=%b led=%b, want 0/0/%b", done, busy, led, IDLE_PATTERN);
    else npass++;
    @(negedge sys_clk);
    ntot++;
    if (done !== 1'b0) $display("FAIL final_stop_late: done=%b, want 0", done);
    else npass++;
  endtask

  task automatic test_async_reset_mid_run();
    fill_random();
    seq_len = 4'd6; dwell = 24'd3; loop_cnt = 8'd2; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (12) @(negedge sys_clk);
    ntot++;
    if (led !== tbl[3] || busy !== 1'b1)
      $display("FAIL pre_reset_step3: led=%b busy=%b, want %b/1", led, busy, tbl[3]);
    else npass++;
    #2 sys_rst_n = 1'b0;
    #1;
    ntot++;
    if (led !== IDLE_PATTERN || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0)
      $display("FAIL mid_run_reset: led=%b busy=%b done=%b cfg_err=%b, want %b/0/0/0",
               led, busy, done, cfg_err, IDLE_PATTERN);
    else npass++;
    for (int a = 0; a < DEPTH; a++) tbl[a] = '0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    test_play(8, 0, 1, 1'b0, "table_cleared");
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_random_finite();
    test_infinite();
    test_bad_len();
    test_write_in_run();
    test_start_stop_idle();
    test_stop_on_final();
    test_async_reset_mid_run();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
